beid_ahb_mtx_input_stage: RTL



---
 rtl/beid_ahb_mtx_input_stage.sv | 126 ++++++++++++
 1 files changed

// File: rtl/beid_ahb_mtx_input_stage.sv
// Per-master input stage of the beid AHB matrix: holds stalled address phases and returns data-phase ready/response.
// Optional feature: define BEID_MTX_INSTAGE_PROT_EN to hold and forward HPROTS; otherwise prot_out is a constant 4'b0011.
module beid_ahb_mtx_input_stage #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  output logic                  HREADYOUTS,
  output logic [1:0]            HRESPS,
  input  logic                  addr_accept,
  input  logic                  dp_ready,
  input  logic [1:0]            dp_resp,
  output logic                  req_port,
  output logic [1:0]            trans_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  write_out,
  output logic [2:0]            size_out,
  output logic [2:0]            burst_out,
  output logic [3:0]            prot_out,
  output logic                  lock_out,
  output logic                  held
);

  logic                  live_valid;
  logic                  capture;
  logic                  reg_hold;
  logic                  reg_dp;
  logic [1:0]            hold_trans;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic                  hold_write;
  logic [2:0]            hold_size;
  logic [2:0]            hold_burst;
  logic                  hold_lock;

  assign live_valid = HSELS & HREADYS & HTRANSS[1];
  // The master is stalled while a hold exists, so a new capture can never overwrite it.
  assign capture    = live_valid & ~addr_accept & ~reg_hold;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      reg_hold   <= 1'b0;
      hold_trans <= 2'b00;
      hold_addr  <= '0;
      hold_write <= 1'b0;
      hold_size  <= 3'b000;
      hold_burst <= 3'b000;
      hold_lock  <= 1'b0;
    end else if (capture) begin
      reg_hold   <= 1'b1;
      hold_trans <= HTRANSS;
      hold_addr  <= HADDRS;
      hold_write <= HWRITES;
      hold_size  <= HSIZES;
      hold_burst <= HBURSTS;
      hold_lock  <= HMASTLOCKS;
    end else if (reg_hold && addr_accept) begin
      reg_hold   <= 1'b0;
    end
  end

  // A stray accept with nothing to offer still opens a data phase.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      reg_dp <= 1'b0;
    end else if (addr_accept) begin
      reg_dp <= 1'b1;
    end else if (dp_ready) begin
      reg_dp <= 1'b0;
    end
  end

`ifdef BEID_MTX_INSTAGE_PROT_EN
  logic [3:0] hold_prot;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      hold_prot <= 4'b0000;
    end else if (capture) begin
      hold_prot <= HPROTS;
    end
  end

  assign prot_out = reg_hold ? hold_prot : HPROTS;
`else
  logic unused_prot;

  assign unused_prot = ^HPROTS;
  assign prot_out    = 4'b0011;
`endif

  assign held       = reg_hold;
  assign req_port   = reg_hold | live_valid;
  assign trans_out  = reg_hold ? hold_trans : HTRANSS;
  assign addr_out   = reg_hold ? hold_addr  : HADDRS;
  assign write_out  = reg_hold ? hold_write : HWRITES;
  assign size_out   = reg_hold ? hold_size  : HSIZES;
  assign burst_out  = reg_hold ? hold_burst : HBURSTS;
  assign lock_out   = reg_hold ? hold_lock  : HMASTLOCKS;

  always_comb begin
    HREADYOUTS = 1'b1;
    if (reg_hold) begin
      HREADYOUTS = 1'b0;
    end else if (reg_dp) begin
      HREADYOUTS = dp_ready;
    end
  end

  assign HRESPS = reg_dp ? dp_resp : 2'b00;

`ifndef SYNTHESIS
  // Upstream protocol check: the matrix must only accept a port that is actually requesting.
  a_accept_needs_req: assert property (@(posedge HCLK) disable iff (HRESET)
    !(addr_accept && !reg_hold && !live_valid));
`endif

endmodule
